// File: rtl/bcd_contador_display_pkg.sv
// Shared constants and helpers for the two-digit BCD counter and its display scan.
package bcd_contador_display_pkg;

   localparam int         BCD_W     = 4;
   localparam logic [3:0] BCD_MAX   = 4'd9;
   localparam logic [1:0] SEL_UNITS = 2'b01;
   localparam logic [1:0] SEL_TENS  = 2'b10;

   typedef logic [BCD_W-1:0] bcd_t;

   function automatic logic is_bcd(input bcd_t d);
      return d <= BCD_MAX;
   endfunction

   // Counter width for a 0..n-1 range; a one-state counter still needs one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bcd_contador_display_bcd_digit.sv
// Single BCD digit: mod-(limit+1) up/down counter with clear and load.
module bcd_digit
   import bcd_contador_display_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic       inc,
   input  logic       dec,
   input  bcd_t       load_val,
   input  bcd_t       limit,
   output bcd_t       q,
   output logic       carry,
   output logic       borrow
);

   // Carry/borrow depend only on inc/dec and q, never on load, so the top
   // can route a borrow back into load without a combinational loop.
   assign carry  = inc && (q == limit);
   assign borrow = dec && (q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (inc) begin
         q <= (q == limit) ? '0 : q + 4'd1;
      end else if (dec) begin
         q <= (q == '0) ? limit : q - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_contador_display.sv
// Two-digit BCD up/down counter with prescaler, checked load, wrap pulse
// and a time-multiplexed digit/select pair for a shared 7-segment decoder.
module bcd_contador_display
   import bcd_contador_display_pkg::*;
#(
   parameter int PRESCALE  = 4,
   parameter int MAX_TENS  = 5,
   parameter int MAX_UNITS = 9,
   parameter int SCAN_DIV  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_units,
   output logic [3:0] tens_q,
   output logic [3:0] units_q,
   output logic       tc,
   output logic       load_err,
   output logic [1:0] scan_sel,
   output logic [3:0] scan_digit
);

   localparam int   PW = cnt_w(PRESCALE);
   localparam int   SW = cnt_w(SCAN_DIV);
   localparam bcd_t MT = 4'(MAX_TENS);
   localparam bcd_t MU = 4'(MAX_UNITS);

   logic [PW-1:0] pre;
   logic [SW-1:0] scan_cnt;
   logic          pre_last;
   logic          step;
   logic          step_go;
   logic          load_ok;
   logic          units_inc;
   logic          units_dec;
   logic          units_carry;
   logic          units_borrow;
   logic          tens_carry;
   logic          tens_borrow;
   logic          dig_load;
   bcd_t          units_limit;
   bcd_t          units_load_val;
   bcd_t          tens_load_val;

   assign pre_last = (pre == PW'(PRESCALE - 1));
   assign step     = en && pre_last;
   assign step_go  = step && !clr && !load;

   assign load_ok = load && is_bcd(load_units) && (load_tens <= MT)
                    && ((load_tens < MT) || (load_units <= MU));

   assign units_inc = step_go && up;
   assign units_dec = step_go && !up;

   // Counting up in the top decade the units roll over at MAX_UNITS; every
   // other case (including borrow into a lower decade) rolls at 9.
   assign units_limit = (up && (tens_q == MT)) ? MU : BCD_MAX;

   // A borrow out of the tens digit means 00 stepped down: reload the terminal value.
   assign dig_load       = load_ok || tens_borrow;
   assign units_load_val = load_ok ? load_units : MU;
   assign tens_load_val  = load_ok ? load_tens  : MT;

   bcd_digit u_units (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (dig_load),
      .inc      (units_inc),
      .dec      (units_dec),
      .load_val (units_load_val),
      .limit    (units_limit),
      .q        (units_q),
      .carry    (units_carry),
      .borrow   (units_borrow)
   );

   bcd_digit u_tens (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (dig_load),
      .inc      (units_carry),
      .dec      (units_borrow),
      .load_val (tens_load_val),
      .limit    (MT),
      .q        (tens_q),
      .carry    (tens_carry),
      .borrow   (tens_borrow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else if (clr || load_ok) begin
         pre <= '0;
      end else if (en) begin
         pre <= pre_last ? '0 : pre + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tc <= 1'b0;
      end else begin
         tc <= tens_carry || tens_borrow;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_err <= 1'b0;
      end else begin
         load_err <= load && !clr && !load_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_sel <= SEL_UNITS;
      end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         scan_sel <= (scan_sel == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   assign scan_digit = (scan_sel == SEL_TENS) ? tens_q : units_q;

endmodule
